// File: rtl/fgs_pkg.sv
// fgs_pkg: shared types and defaults for the template-window scan controller.
// Optional feature macro used by the controller: FGS_STALL_EN (adds mem_ready back-pressure).
package fgs_pkg;

    // Controller states: idle, per-row bubble, read issue, pipeline drain.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LINE  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Default geometry of the stereo sum datapath.
    localparam int WIN_DEF    = 16;
    localparam int NDISP_DEF  = 64;
    localparam int IMG_W_DEF  = 320;
    localparam int AW_DEF     = 17;
    localparam int RD_LAT_DEF = 2;

    // Fixed widths of the read-side index outputs.
    localparam int COL_W = 7;
    localparam int ROW_W = 4;

    // Issue-side strobes that travel through the read-latency delay line.
    typedef struct packed {
        logic             row_start;
        logic             pix_valid;
        logic             f_acc;
        logic [COL_W-1:0] col_idx;
        logic [ROW_W-1:0] row_idx;
    } strobe_t;

    // Number of g columns visited per row: the window plus the disparity sweep.
    function automatic int col_count(input int win, input int ndisp);
        return win + ndisp - 1;
    endfunction

endpackage

// File: rtl/fgs_strobe_delay.sv
// fgs_strobe_delay: RD_LAT-deep shift register that re-times issue-side strobes
// so they line up with data returned by the image memories.
module fgs_strobe_delay
    import fgs_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  strobe_t din,
    output strobe_t dout,
    output logic    pending
);

    strobe_t          stage_q [RD_LAT];
    logic [RD_LAT-1:0] stage_valid;

    // Shift every cycle; a cleared stage is a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Any valid pixel still in flight keeps the controller in DRAIN.
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_valid
            assign stage_valid[gi] = stage_q[gi].pix_valid;
        end
    endgenerate

    assign pending = |stage_valid;
    assign dout    = stage_q[RD_LAT-1];

endmodule

// File: rtl/fgs_scan_ctrl.sv
// fgs_scan_ctrl: start/done sequencer for the 16x16 template-window sum datapath.
// Walks the window row by row, issuing f and g pixel reads across the disparity
// sweep, and emits read-aligned accumulate strobes.
// Optional feature macro: FGS_STALL_EN adds mem_ready, which gates reads in ISSUE.
module fgs_scan_ctrl
    import fgs_pkg::*;
#(
    parameter int WIN    = WIN_DEF,
    parameter int NDISP  = NDISP_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    x0,
    input  logic [AW-1:0]    y0,
`ifdef FGS_STALL_EN
    input  logic             mem_ready,
`endif
    output logic             busy,
    output logic             done,
    output logic             f_rd_en,
    output logic [AW-1:0]    f_addr,
    output logic             g_rd_en,
    output logic [AW-1:0]    g_addr,
    output logic             row_start,
    output logic             pix_valid,
    output logic             f_acc,
    output logic [COL_W-1:0] col_idx,
    output logic [ROW_W-1:0] row_idx
);

    localparam int               COLS     = col_count(WIN, NDISP);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] F_COLS   = COL_W'(WIN);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WIN - 1);
    localparam logic [AW-1:0]    PITCH    = AW'(IMG_W);

    state_t           state_q, state_d;
    logic [AW-1:0]    y_off_q, y_off_d;
    logic [AW-1:0]    x0_q, x0_d;
    logic [AW-1:0]    row_base_q, row_base_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic             issue_ok;
    logic             pipe_pending;
    logic [AW-1:0]    cur_addr;
    strobe_t          issue_s;
    strobe_t          read_s;

`ifdef FGS_STALL_EN
    assign issue_ok = mem_ready;
`else
    assign issue_ok = 1'b1;
`endif

    // Controller state, registered row offset multiply and scan counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            y_off_q    <= '0;
            x0_q       <= '0;
            row_base_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            y_off_q    <= y_off_d;
            x0_q       <= x0_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    // Next-state logic and issue-side strobes; only row 0 uses the multiply,
    // later rows step the base by one image line.
    always_comb begin
        state_d    = state_q;
        y_off_d    = y_off_q;
        x0_d       = x0_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        row_d      = row_q;
        f_rd_en    = 1'b0;
        g_rd_en    = 1'b0;
        done       = 1'b0;
        issue_s    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    y_off_d = y0 * PITCH;
                    x0_d    = x0;
                    row_d   = '0;
                    state_d = LINE;
                end
            end

            LINE: begin
                if (row_q == '0) begin
                    row_base_d = y_off_q + x0_q;
                end else begin
                    row_base_d = row_base_q + PITCH;
                end
                col_d   = '0;
                state_d = ISSUE;
            end

            ISSUE: begin
                if (issue_ok) begin
                    g_rd_en           = 1'b1;
                    f_rd_en           = (col_q < F_COLS);
                    issue_s.row_start = (col_q == '0);
                    issue_s.pix_valid = 1'b1;
                    issue_s.f_acc     = (col_q < F_COLS);
                    issue_s.col_idx   = col_q;
                    issue_s.row_idx   = row_q;
                    if (col_q == COL_LAST) begin
                        if (row_q == ROW_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = LINE;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            DRAIN: begin
                if (!pipe_pending) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Addresses are held through stalls and forced to zero outside ISSUE.
    assign cur_addr = row_base_q + AW'(col_q);
    assign g_addr   = (state_q == ISSUE) ? cur_addr : '0;
    assign f_addr   = ((state_q == ISSUE) && (col_q < F_COLS)) ? cur_addr : '0;
    assign busy     = (state_q != IDLE);

    fgs_strobe_delay #(
        .RD_LAT (RD_LAT)
    ) u_strobe_delay (
        .clk     (clk),
        .rst     (rst),
        .din     (issue_s),
        .dout    (read_s),
        .pending (pipe_pending)
    );

    assign row_start = read_s.row_start;
    assign pix_valid = read_s.pix_valid;
    assign f_acc     = read_s.f_acc;
    assign col_idx   = read_s.col_idx;
    assign row_idx   = read_s.row_idx;

endmodule

// File: tb/tb_fgs_scan_ctrl.sv
// tb_fgs_scan_ctrl: self-checking bench for fgs_scan_ctrl (small 4x4 window).
// Expected reads and strobes come from a geometric model of the scan.
module tb_fgs_scan_ctrl;

    localparam int  WIN    = 4;
    localparam int  NDISP  = 4;
    localparam int  IMG_W  = 20;
    localparam int  AW     = 17;
    localparam int  RD_LAT = 2;
    localparam int  COLS   = WIN + NDISP - 1;
    localparam longint MASK = (64'd1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] x0, y0;
    logic          busy, done, f_rd_en, g_rd_en;
    logic [AW-1:0] f_addr, g_addr;
    logic          row_start, pix_valid, f_acc;
    logic [6:0]    col_idx;
    logic [3:0]    row_idx;
`ifdef FGS_STALL_EN
    logic          mem_ready;
`endif

    always #5 clk = ~clk;

    fgs_scan_ctrl #(
        .WIN(WIN), .NDISP(NDISP), .IMG_W(IMG_W), .AW(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
`ifdef FGS_STALL_EN
        .mem_ready(mem_ready),
`endif
        .busy(busy), .done(done),
        .f_rd_en(f_rd_en), .f_addr(f_addr), .g_rd_en(g_rd_en), .g_addr(g_addr),
        .row_start(row_start), .pix_valid(pix_valid), .f_acc(f_acc),
        .col_idx(col_idx), .row_idx(row_idx)
    );

    typedef struct { longint addr; int n; } rd_t;
    typedef struct { int r; int c; int rs; int fa; int n; } pv_t;
    typedef struct { int x0; int y0; int extra_n; longint first_g; longint last_g; int done_n; } vec_t;

    rd_t g_obs[$], f_obs[$], g_exp[$], f_exp[$];
    pv_t pv_obs[$], pv_exp[$];
    int  done_n_obs, done_cnt, busy_bad, stray_rs;
    int  stall_lo = 0, stall_hi = -1;
    int  probe_n = -1;
    longint probe_val;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: rows of the window, columns of the sweep, one LINE cycle per row,
    // issue cycles pushed past any stall window, data returning RD_LAT later.
    task automatic build_model(input int xv, input int yv, output int done_exp);
        int t;
        longint a;
        g_exp.delete(); f_exp.delete(); pv_exp.delete();
        t = 0;
        for (int r = 0; r < WIN; r++) begin
            t++;
            for (int c = 0; c < COLS; c++) begin
                t++;
                while (t >= stall_lo && t <= stall_hi) t++;
                a = (longint'(yv + r) * IMG_W + xv + c) & MASK;
                g_exp.push_back('{a, t});
                if (c < WIN) f_exp.push_back('{a, t});
                pv_exp.push_back('{r, c, (c == 0) ? 1 : 0, (c < WIN) ? 1 : 0, t + RD_LAT});
            end
        end
        done_exp = t + RD_LAT + 1;
    endtask

    task automatic sample(input int n, input int done_exp);
        if (g_rd_en) g_obs.push_back('{longint'(g_addr), n});
        if (f_rd_en) f_obs.push_back('{longint'(f_addr), n});
        if (pix_valid) pv_obs.push_back('{int'(row_idx), int'(col_idx), int'(row_start), int'(f_acc), n});
        if ((row_start || f_acc) && !pix_valid) stray_rs++;
        if (done) begin done_cnt++; done_n_obs = n; end
        if (busy !== (n <= done_exp)) busy_bad++;
        if (n == probe_n) probe_val = longint'(g_addr);
    endtask

    // Called just after a negedge; start is sampled by the next rising edge (k).
    task automatic run_scan(input int xv, input int yv, input int extra_n, output int done_exp);
        g_obs.delete(); f_obs.delete(); pv_obs.delete();
        done_n_obs = -1; done_cnt = 0; busy_bad = 0; stray_rs = 0;
        build_model(xv, yv, done_exp);
        x0 = AW'(xv); y0 = AW'(yv); start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= done_exp + 1; n++) begin
            #1;
            start = (n == extra_n);
            if (n == extra_n) begin x0 = AW'(5); y0 = AW'(3); end
`ifdef FGS_STALL_EN
            mem_ready = !(n >= stall_lo && n <= stall_hi);
`endif
            @(negedge clk);
            sample(n, done_exp);
            if (n <= done_exp) @(posedge clk);
        end
        start = 1'b0;
`ifdef FGS_STALL_EN
        mem_ready = 1'b1;
`endif
        check("g_count", g_obs.size(), g_exp.size());
        for (int i = 0; i < g_exp.size() && i < g_obs.size(); i++) begin
            check("g_addr", g_obs[i].addr, g_exp[i].addr);
            check("g_cycle", g_obs[i].n, g_exp[i].n);
        end
        check("f_count", f_obs.size(), f_exp.size());
        for (int i = 0; i < f_exp.size() && i < f_obs.size(); i++) begin
            check("f_addr", f_obs[i].addr, f_exp[i].addr);
            check("f_cycle", f_obs[i].n, f_exp[i].n);
        end
        check("pix_count", pv_obs.size(), pv_exp.size());
        for (int i = 0; i < pv_exp.size() && i < pv_obs.size(); i++) begin
            check("pix_row", pv_obs[i].r, pv_exp[i].r);
            check("pix_col", pv_obs[i].c, pv_exp[i].c);
            check("pix_row_start", pv_obs[i].rs, pv_exp[i].rs);
            check("pix_f_acc", pv_obs[i].fa, pv_exp[i].fa);
            check("pix_cycle", pv_obs[i].n, pv_exp[i].n);
        end
        check("done_cycle", done_n_obs, done_exp);
        check("done_pulses", done_cnt, 1);
        check("busy_bad_cycles", busy_bad, 0);
        check("stray_strobes", stray_rs, 0);
        $display("scan x0=%0d y0=%0d extra_start=%0d: g=%0d f=%0d pix=%0d done@+%0d",
                 xv, yv, extra_n, g_obs.size(), f_obs.size(), pv_obs.size(), done_n_obs);
    endtask

    function automatic longint all_outputs();
        return longint'({busy, done, f_rd_en, g_rd_en, row_start, pix_valid, f_acc})
             | longint'(f_addr) | longint'(g_addr) | longint'(col_idx) | longint'(row_idx);
    endfunction

    vec_t tbl[5];

    initial begin
        int dn, cnt, gap;

        // x0, y0, extra start cycle, first g addr, last g addr, done cycle
        tbl[0] = '{2, 1, 0, 22, 88, 35};
        tbl[1] = '{2, 1, 10, 22, 88, 35};
        tbl[2] = '{0, 0, 35, 0, 66, 35};
        tbl[3] = '{13, 10, 0, 213, 279, 35};
        tbl[4] = '{10, 6553, 0, 131070, 64, 35};

        rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0;
`ifdef FGS_STALL_EN
        mem_ready = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", all_outputs(), 0);

        // Table vectors run back to back: each start lands in the cycle busy falls.
        for (int i = 0; i < 5; i++) begin
            run_scan(tbl[i].x0, tbl[i].y0, tbl[i].extra_n, dn);
            check("tbl_first_g", (g_obs.size() > 0) ? g_obs[0].addr : -1, tbl[i].first_g);
            check("tbl_last_g", (g_obs.size() > 0) ? g_obs[g_obs.size()-1].addr : -1, tbl[i].last_g);
            check("tbl_done_n", done_n_obs, tbl[i].done_n);
        end

        // Mid-scan reset: no done afterwards, outputs cleared the cycle after.
        @(negedge clk);
        x0 = AW'(2); y0 = AW'(1); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("busy_before_reset", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", all_outputs(), 0);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("no_activity_after_reset", cnt, 0);
        run_scan(2, 1, 0, dn);

`ifdef FGS_STALL_EN
        // Stall during row 1, column 3: address holds, done slips by three.
        @(negedge clk);
        stall_lo = 13; stall_hi = 15; probe_n = 14;
        run_scan(2, 1, 0, dn);
        check("stall_done_n", done_n_obs, 38);
        check("stall_g_hold", probe_val, 45);
        check("stall_pix_count", pv_obs.size(), 28);
        stall_lo = 0; stall_hi = -1; probe_n = -1;
`endif

        // Randomized scans against the model.
        for (int it = 0; it < 8; it++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
`ifdef FGS_STALL_EN
            stall_lo = $urandom_range(2, 30);
            stall_hi = stall_lo + $urandom_range(0, 3) - 1;
`endif
            run_scan($urandom_range(0, 13), $urandom_range(0, 6000),
                     ($urandom_range(0, 1) == 1) ? $urandom_range(3, 30) : 0, dn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
